// File: rtl/demux_1to2_stream.sv
// Registered 1-to-2 stream demux.
// Packets are steered by in_sel on their first beat into per-output 2-deep FIFOs.
module demux_1to2_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;

  assign valid = (count != 2'd0);
  assign head  = mem[rp];

  // Storage, pointers and fill count; push and pop may occur together.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

module demux_1to2_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t     state;
  state_t     state_n;
  logic       route;
  logic       acc;
  logic       push0;
  logic       push1;
  logic       pop0;
  logic       pop1;
  logic [1:0] fill0;
  logic [1:0] fill1;

  assign acc   = in_valid & in_ready;
  assign push0 = acc & ~route;
  assign push1 = acc & route;
  assign pop0  = out0_valid & out0_ready;
  assign pop1  = out1_valid & out1_ready;

  // Route target and next state; in_ready uses registered fills only.
  always_comb begin
    state_n = state;
    route   = in_sel;
    case (state)
      LOCK0:   route = 1'b0;
      LOCK1:   route = 1'b1;
      default: route = in_sel;
    endcase
    in_ready = route ? (fill1 < 2'd2) : (fill0 < 2'd2);
    if (in_valid && in_ready) begin
      case (state)
        IDLE: begin
          if (!in_last) state_n = in_sel ? LOCK1 : LOCK0;
        end
        LOCK0, LOCK1: begin
          if (in_last) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Packet lock state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Wrapping per-output transfer counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0) cnt0 <= cnt0 + 1'b1;
      if (pop1) cnt1 <= cnt1 + 1'b1;
    end
  end

  demux_1to2_fifo2 #(.W(DATA_W + 1)) u_f0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .din   ({in_last, in_data}),
    .pop   (pop0),
    .valid (out0_valid),
    .head  ({out0_last, out0_data}),
    .count (fill0)
  );

  demux_1to2_fifo2 #(.W(DATA_W + 1)) u_f1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .din   ({in_last, in_data}),
    .pop   (pop1),
    .valid (out1_valid),
    .head  ({out1_last, out1_data}),
    .count (fill1)
  );

endmodule
